// File: rtl/mealy_stim_tx.sv
// Serial frame transmitter for a two-consecutive-ones Mealy detector.
// Sends a parallel word MSB-first with a trailing guard 0 and reports the expected z=1 count.
module mealy_stim_tx #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LEN_W  = $clog2(DATA_W + 1)
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_load_valid,
    output logic              o_load_ready,
    input  logic [DATA_W-1:0] i_load_data,
    input  logic [LEN_W-1:0]  i_load_len,
    output logic              o_w,
    output logic              o_w_valid,
    output logic              o_done,
    output logic [LEN_W-1:0]  o_exp_count
);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StGuard
    } state_e;

    state_e             r_state;
    logic [DATA_W-1:0]  r_shreg;
    logic [LEN_W-1:0]   r_bits_left;
    logic               r_prev;
    logic [LEN_W-1:0]   r_run;
    logic               r_w;
    logic               r_w_valid;
    logic               r_done;
    logic [LEN_W-1:0]   r_exp_count;

    state_e             w_state_nxt;
    logic [DATA_W-1:0]  w_shreg_nxt;
    logic [LEN_W-1:0]   w_bits_left_nxt;
    logic               w_prev_nxt;
    logic [LEN_W-1:0]   w_run_nxt;
    logic               w_w_nxt;
    logic               w_w_valid_nxt;
    logic               w_done_nxt;
    logic [LEN_W-1:0]   w_exp_count_nxt;

    logic               w_handshake;
    logic [LEN_W-1:0]   w_len;
    logic [DATA_W-1:0]  w_aligned;
    logic               w_head;
    logic               w_next_bit;

    assign o_load_ready = (r_state == StIdle) && !i_reset;
    assign w_handshake  = i_load_valid && o_load_ready;
    assign w_len        = (i_load_len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : i_load_len;
    // Left-align the frame so its first bit sits in the MSB.
    assign w_aligned    = i_load_data << (LEN_W'(DATA_W) - w_len);
    assign w_head       = w_aligned[DATA_W-1];
    assign w_next_bit   = r_shreg[DATA_W-1];

    assign o_w          = r_w;
    assign o_w_valid    = r_w_valid;
    assign o_done       = r_done;
    assign o_exp_count  = r_exp_count;

    always_comb begin
        w_state_nxt     = r_state;
        w_shreg_nxt     = r_shreg;
        w_bits_left_nxt = r_bits_left;
        w_prev_nxt      = r_prev;
        w_run_nxt       = r_run;
        w_exp_count_nxt = r_exp_count;
        w_w_nxt         = 1'b0;
        w_w_valid_nxt   = 1'b0;
        w_done_nxt      = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (w_handshake) begin
                    if (w_len == '0) begin
                        w_done_nxt      = 1'b1;
                        w_exp_count_nxt = '0;
                    end else begin
                        // First bit goes out on the capture edge; prev=0 so it never counts.
                        w_state_nxt     = StShift;
                        w_w_nxt         = w_head;
                        w_w_valid_nxt   = 1'b1;
                        w_shreg_nxt     = w_aligned << 1;
                        w_bits_left_nxt = w_len - 1'b1;
                        w_prev_nxt      = w_head;
                        w_run_nxt       = '0;
                    end
                end
            end
            StShift: begin
                if (r_bits_left != '0) begin
                    w_w_nxt         = w_next_bit;
                    w_w_valid_nxt   = 1'b1;
                    w_shreg_nxt     = r_shreg << 1;
                    w_bits_left_nxt = r_bits_left - 1'b1;
                    w_run_nxt       = r_run + LEN_W'(r_prev & w_next_bit);
                    w_prev_nxt      = w_next_bit;
                end else begin
                    w_state_nxt     = StGuard;
                    w_done_nxt      = 1'b1;
                    w_exp_count_nxt = r_run;
                end
            end
            StGuard: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_shreg     <= '0;
            r_bits_left <= '0;
            r_prev      <= 1'b0;
            r_run       <= '0;
            r_w         <= 1'b0;
            r_w_valid   <= 1'b0;
            r_done      <= 1'b0;
            r_exp_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_shreg     <= w_shreg_nxt;
            r_bits_left <= w_bits_left_nxt;
            r_prev      <= w_prev_nxt;
            r_run       <= w_run_nxt;
            r_w         <= w_w_nxt;
            r_w_valid   <= w_w_valid_nxt;
            r_done      <= w_done_nxt;
            r_exp_count <= w_exp_count_nxt;
        end
    end

endmodule

// File: tb/tb_mealy_stim_tx.sv
// Directed bench for mealy_stim_tx with a behavioural two-ones Mealy detector as scoreboard.
module tb_mealy_stim_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = 8'h00;
    logic [3:0] load_len = 4'd0;
    logic       load_ready;
    logic       w;
    logic       w_valid;
    logic       done;
    logic [3:0] exp_count;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mealy_stim_tx #(
        .DATA_W(8),
        .LEN_W (4)
    ) u_dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_load_valid(load_valid),
        .o_load_ready(load_ready),
        .i_load_data (load_data),
        .i_load_len  (load_len),
        .o_w         (w),
        .o_w_valid   (w_valid),
        .o_done      (done),
        .o_exp_count (exp_count)
    );

    // Detector: state B after a 1; z = B && w. z_cnt restarts after each done.
    logic       det_b;
    logic [3:0] z_cnt;
    always @(posedge clk) begin
        if (rst) begin
            det_b <= 1'b0;
            z_cnt <= 4'd0;
        end else begin
            det_b <= w;
            z_cnt <= done ? 4'd0 : z_cnt + {3'b000, det_b & w};
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Called in cycle 0 after the capture edge; returns in the first IDLE cycle.
    task automatic run_frame(input string name, input logic [7:0] bits, input int n,
                             input int cnt);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_bit%0d", name, i), 32'(w), 32'(bits[7-i]));
            check($sformatf("%s_valid%0d", name, i), 32'(w_valid), 32'd1);
            if (i == 0 || i == n - 1) begin
                check($sformatf("%s_nodone%0d", name, i), 32'(done), 32'd0);
                check($sformatf("%s_busy%0d", name, i), 32'(load_ready), 32'd0);
            end
            tick();
        end
        check({name, "_guard_w"}, 32'(w), 32'd0);
        check({name, "_guard_valid"}, 32'(w_valid), 32'd0);
        check({name, "_done"}, 32'(done), 32'd1);
        check({name, "_guard_busy"}, 32'(load_ready), 32'd0);
        check({name, "_exp_count"}, 32'(exp_count), 32'(cnt));
        check({name, "_det_vs_exp"}, 32'(z_cnt), 32'(exp_count));
        tick();
        check({name, "_ready_back"}, 32'(load_ready), 32'd1);
        check({name, "_done_low"}, 32'(done), 32'd0);
    endtask

    task automatic send_frame(input string name, input logic [7:0] data, input logic [3:0] len,
                              input logic [7:0] bits, input int n, input int cnt);
        check({name, "_ready"}, 32'(load_ready), 32'd1);
        load_valid = 1'b1;
        load_data  = data;
        load_len   = len;
        tick();
        load_valid = 1'b0;
        run_frame(name, bits, n, cnt);
    endtask

    initial begin
        int dones;

        // 1: reset
        rst = 1'b1;
        tick();
        tick();
        check("rst_w", 32'(w), 32'd0);
        check("rst_valid", 32'(w_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_exp", 32'(exp_count), 32'd0);
        check("rst_ready_low", 32'(load_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_ready_high", 32'(load_ready), 32'd1);
        tick();

        // 2: full-length frame
        send_frame("b6", 8'hB6, 4'd8, 8'b1011_0110, 8, 2);

        // 3: short frame and over-length clamp
        send_frame("07", 8'h07, 4'd3, 8'b1110_0000, 3, 2);
        send_frame("ff12", 8'hFF, 4'd12, 8'b1111_1111, 8, 7);

        // 4: empty frame
        check("len0_ready", 32'(load_ready), 32'd1);
        load_valid = 1'b1;
        load_data  = 8'hFF;
        load_len   = 4'd0;
        tick();
        load_valid = 1'b0;
        check("len0_done", 32'(done), 32'd1);
        check("len0_valid", 32'(w_valid), 32'd0);
        check("len0_exp", 32'(exp_count), 32'd0);
        check("len0_det", 32'(z_cnt), 32'd0);
        tick();
        check("len0_done_low", 32'(done), 32'd0);
        check("len0_valid_low", 32'(w_valid), 32'd0);

        // 5: load_valid held through SHIFT/GUARD with new contents
        check("hold_ready", 32'(load_ready), 32'd1);
        load_valid = 1'b1;
        load_data  = 8'h05;
        load_len   = 4'd3;
        tick();
        load_data  = 8'h03;
        load_len   = 4'd2;
        run_frame("hold1", 8'b1010_0000, 3, 0);
        check("hold_idle_valid", 32'(w_valid), 32'd0);
        tick();
        load_valid = 1'b0;
        run_frame("hold2", 8'b1100_0000, 2, 1);

        // 6: reset during bit 4 of an 8-bit frame
        check("mid_ready", 32'(load_ready), 32'd1);
        load_valid = 1'b1;
        load_data  = 8'hB6;
        load_len   = 4'd8;
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        check("mid_bit4", 32'(w), 32'd0);
        check("mid_valid4", 32'(w_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_ready_in_rst", 32'(load_ready), 32'd0);
        tick();
        rst = 1'b0;
        check("mid_w", 32'(w), 32'd0);
        check("mid_valid", 32'(w_valid), 32'd0);
        check("mid_done", 32'(done), 32'd0);
        check("mid_exp", 32'(exp_count), 32'd0);
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done || w_valid) dones++;
        end
        check("mid_no_done", 32'(dones), 32'd0);
        send_frame("after", 8'hB6, 4'd8, 8'b1011_0110, 8, 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
